// File: rtl/seq_pkg.sv
// Shared constants for the sequence generator/detector pair: term table,
// idle fill value and the generator FSM state encoding.
package seq_pkg;

  localparam int unsigned SEQ_LEN = 8;
  localparam int unsigned TERM_W  = 3;

  localparam logic [TERM_W-1:0] IDLE_VALUE = 3'b111;

  localparam logic [TERM_W-1:0] SEQ_TERMS [SEQ_LEN] = '{
    3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101
  };

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } seq_state_t;

  // Whole sequence flattened with term 0 in the most significant slot,
  // matching the oldest-first order of a shift-register window.
  function automatic logic [SEQ_LEN*TERM_W-1:0] seq_packed();
    logic [SEQ_LEN*TERM_W-1:0] word;
    word = '0;
    for (int unsigned i = 0; i < SEQ_LEN; i++) begin
      word[(SEQ_LEN-1-i)*TERM_W +: TERM_W] = SEQ_TERMS[i];
    end
    return word;
  endfunction

endpackage

// File: rtl/sequence_detector.sv
// Free-running detector: flags the cycle on which the final term of the
// shared sequence arrives, given the preceding valid terms.
module sequence_detector
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [TERM_W-1:0] data,
  input  logic              data_valid,
  output logic              sequence_found
);

  localparam logic [SEQ_LEN*TERM_W-1:0] SEQ_WORD = seq_packed();

  logic [(SEQ_LEN-1)*TERM_W-1:0] history;

  // History resets to all-ones: IDLE_VALUE never occurs in the sequence,
  // so a partially filled window cannot match.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      history <= '1;
    end else if (data_valid) begin
      history <= {history[(SEQ_LEN-2)*TERM_W-1:0], data};
    end
  end

  always_comb begin
    sequence_found = data_valid && ({history, data} == SEQ_WORD);
  end

endmodule

// File: rtl/sequence_generator.sv
// Emits the fixed 8-term sequence rep_cnt times with optional idle gaps,
// under valid/ready flow control; all outputs registered.
module sequence_generator
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        rep_cnt,
  input  logic [2:0]        gap,
  input  logic              out_ready,
  output logic [TERM_W-1:0] data,
  output logic              data_valid,
  output logic              last,
  output logic              busy,
  output logic              done
);

  seq_state_t  state;
  logic [2:0]  index;
  logic [3:0]  rep_left;
  logic [2:0]  gap_len;
  logic [2:0]  gap_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      index      <= '0;
      rep_left   <= '0;
      gap_len    <= '0;
      gap_cnt    <= '0;
      data       <= IDLE_VALUE;
      data_valid <= 1'b0;
      last       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rep_left   <= (rep_cnt == '0) ? 4'd1 : rep_cnt;
            gap_len    <= gap;
            index      <= '0;
            data       <= SEQ_TERMS[0];
            data_valid <= 1'b1;
            last       <= 1'b0;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end

        // data_valid is always high in SEND, so out_ready alone is the handshake.
        SEND: begin
          if (out_ready) begin
            if (index != 3'd7) begin
              index <= index + 3'd1;
              data  <= SEQ_TERMS[index + 3'd1];
              last  <= (index == 3'd6);
            end else begin
              rep_left <= rep_left - 4'd1;
              index    <= '0;
              last     <= 1'b0;
              if (rep_left > 4'd1) begin
                if (gap_len == '0) begin
                  data <= SEQ_TERMS[0];
                end else begin
                  gap_cnt    <= gap_len;
                  data       <= IDLE_VALUE;
                  data_valid <= 1'b0;
                  state      <= GAP;
                end
              end else begin
                data       <= IDLE_VALUE;
                data_valid <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
                state      <= DONE;
              end
            end
          end
        end

        GAP: begin
          if (gap_cnt == 3'd1) begin
            gap_cnt    <= '0;
            data       <= SEQ_TERMS[0];
            data_valid <= 1'b1;
            state      <= SEND;
          end else begin
            gap_cnt <= gap_cnt - 3'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator with a looped-back sequence_detector.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] rep_cnt = '0;
  logic [2:0] gap = '0;
  logic       out_ready = 1'b1;
  logic [2:0] data;
  logic       data_valid;
  logic       last;
  logic       busy;
  logic       done;
  logic       sequence_found;

  sequence_generator dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .rep_cnt    (rep_cnt),
    .gap        (gap),
    .out_ready  (out_ready),
    .data       (data),
    .data_valid (data_valid),
    .last       (last),
    .busy       (busy),
    .done       (done)
  );

  sequence_detector det (
    .clk            (clk),
    .reset_n        (reset_n),
    .data           (data),
    .data_valid     (data_valid),
    .sequence_found (sequence_found)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [2:0]  term;
    bit          is_last;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned base = 0;
  bit          mon_en = 0;
  bit          det_en = 0;
  int          found_cnt = 0;
  bit          stalled = 0;
  logic [2:0]  held_data;
  logic        held_last;

  logic [2:0] terms [8] = '{3'b001, 3'b101, 3'b110, 3'b000,
                            3'b110, 3'b110, 3'b011, 3'b101};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rep(input int offset);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.is_done = 0;
      e.term    = terms[i];
      e.is_last = (i == 7);
      e.at      = offset + i;
      sb.push_back(e);
    end
  endtask

  task automatic push_done(input int at);
    exp_t e;
    e.is_done = 1;
    e.term    = 3'b111;
    e.is_last = 0;
    e.at      = at;
    sb.push_back(e);
  endtask

  task automatic issue_start(input logic [3:0] r, input logic [2:0] g);
    rep_cnt = r;
    gap     = g;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    base    = cyc;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    check("drain_remaining", sb.size(), 0);
    tick();
  endtask

  // Monitor: pops expectations on each handshake or done pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      int rel;
      exp_t e;
      rel = int'(cyc) - int'(base);
      if (stalled) begin
        check("hold_valid", int'(data_valid), 1);
        check("hold_data", int'(data), int'(held_data));
        check("hold_last", int'(last), int'(held_last));
      end
      if (data_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_term", int'(data), -1);
        end else begin
          e = sb.pop_front();
          check("term_kind", int'(e.is_done), 0);
          check("term_data", int'(data), int'(e.term));
          check("term_last", int'(last), int'(e.is_last));
          check("term_at", rel, e.at);
          check("busy_sending", int'(busy), 1);
        end
      end
      if (!data_valid) check("idle_data", int'(data), 7);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_kind", int'(e.is_done), 1);
          check("done_at", rel, e.at);
          check("done_busy", int'(busy), 0);
          check("done_valid", int'(data_valid), 0);
        end
      end
      if (det_en) begin
        check("found_vs_last", int'(sequence_found), int'(data_valid && last));
        if (sequence_found) found_cnt++;
      end
      stalled   = data_valid && !out_ready;
      held_data = data;
      held_last = last;
    end
  end

  initial begin
    // Reset held for two cycles, then released with start low.
    tick();
    tick();
    check("rst_data", int'(data), 7);
    check("rst_valid", int'(data_valid), 0);
    check("rst_last", int'(last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_data", int'(data), 7);
    check("post_rst_valid", int'(data_valid), 0);
    check("post_rst_busy", int'(busy), 0);
    mon_en = 1;

    // Single repetition, no gap.
    push_rep(0);
    push_done(8);
    issue_start(4'd1, 3'd0);
    check("first_busy", int'(busy), 1);
    wait_drain(40);

    // Three repetitions with two idle cycles between them.
    push_rep(0);
    push_rep(10);
    push_rep(20);
    push_done(28);
    issue_start(4'd3, 3'd2);
    wait_drain(60);

    // rep_cnt of zero behaves as one.
    push_rep(0);
    push_done(8);
    issue_start(4'd0, 3'd5);
    wait_drain(40);

    // Sink stalls for three cycles while term 2 is presented.
    push_rep(0);
    for (int i = 2; i < 8; i++) sb[i].at = i + 3;
    push_done(11);
    issue_start(4'd1, 3'd0);
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    out_ready = 1'b1;
    wait_drain(40);

    // start during SEND and during DONE is ignored.
    push_rep(0);
    push_done(8);
    issue_start(4'd1, 3'd0);
    tick();
    tick();
    tick();
    rep_cnt = 4'd5;
    start   = 1'b1;
    tick();
    tick();
    start   = 1'b0;
    tick();
    tick();
    tick();
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tick();
    tick();
    tick();
    check("ignored_start_valid", int'(data_valid), 0);
    check("ignored_start_busy", int'(busy), 0);
    check("ignored_start_queue", sb.size(), 0);

    // Reset while term 4 is presented aborts without a done pulse.
    push_rep(0);
    for (int i = 0; i < 3; i++) void'(sb.pop_back());
    issue_start(4'd2, 3'd1);
    tick();
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_data", int'(data), 7);
    check("abort_valid", int'(data_valid), 0);
    check("abort_done", int'(done), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_queue", sb.size(), 0);
    tick();
    tick();
    tick();

    // Restart after abort begins from term 0.
    push_rep(0);
    push_done(8);
    issue_start(4'd1, 3'd0);
    wait_drain(40);

    // Loopback: three back-to-back repetitions seen by the detector.
    det_en    = 1;
    found_cnt = 0;
    push_rep(0);
    push_rep(8);
    push_rep(16);
    push_done(24);
    issue_start(4'd3, 3'd0);
    wait_drain(60);
    det_en = 0;
    check("found_count", found_cnt, 3);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset, with ports as follows:
  - clk  input  1  single clock, rising edge
  - reset_n  input  1  synchronous, active-low reset
REQ-002 start  input  1  request to begin transmission; sampled only while idle.
REQ-003 rep_cnt  input  4  number of back-to-back sequences to send; latched on accepted start; 0 is treated as 1.
REQ-004 gap  input  3  idle cycles inserted between repetitions; latched on accepted start.
REQ-005 out_ready  input  1  sink accepts the current term; tie to 1 when driving a free-running detector.
REQ-006 data  output  3  current sequence term; IDLE_VALUE (3'b111) when not sending.
REQ-007 data_valid  output  1  data holds a sequence term.
REQ-008 last  output  1  high with the 8th term (3'b101) of each repetition.
REQ-009 busy  output  1  high from the cycle after an accepted start until the done cycle.
REQ-010 done  output  1  one-cycle completion pulse.

Function
REQ-011 Sequence terms, index 0..7, SHALL be: 001, 101, 110, 000, 110, 110, 011, 101.
REQ-012 FSM states SHALL be IDLE, SEND, GAP and DONE.
REQ-013 IDLE: start=1 at edge N SHALL latch rep_cnt and gap, then set index=0 and go to SEND; term 0 SHALL be on data with data_valid=1 after edge N.
REQ-014 SEND: a handshake is data_valid && out_ready; each handshake SHALL advance index by 1 on the next edge.
REQ-015 While data_valid=1 and out_ready=0, data, last and index SHALL hold stable, with no skip or repeat.
REQ-016 Handshake on index 7 with repetitions remaining and gap=0: SHALL go directly to index 0, so terms are back-to-back.
REQ-017 Handshake on index 7 with repetitions remaining and gap>0: SHALL enter GAP for exactly gap cycles, driving data=111 and data_valid=0, then return to SEND at index 0.
REQ-018 Handshake on index 7 of the final repetition: SHALL enter DONE for one cycle with done=1, busy=0 and data_valid=0, then return to IDLE.
REQ-019 start asserted outside IDLE, including during DONE, SHALL be ignored.
REQ-020 The repetition counter SHALL be 4 bits, loaded with max(rep_cnt,1) and decremented after each index-7 handshake; it SHALL never wrap.
REQ-021 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-022 While reset_n=0 at a clk edge, the FSM SHALL go to IDLE with data=111, data_valid=0, last=0, busy=0, done=0, index=0 and all counters=0.
REQ-023 Reset asserted mid-SEND or mid-GAP SHALL abort with no done pulse; the next start SHALL begin at term 0.

Structure
REQ-024 Package seq_pkg SHALL hold SEQ_LEN=8, the SEQ_TERMS constant array, IDLE_VALUE=3'b111 and the FSM state enum; sequence_detector SHALL share SEQ_TERMS.
REQ-025 The generator SHALL be a single module; index-to-term lookup SHALL be a constant array index, with no sub-module.

Verification
REQ-026 Reset: hold reset_n=0 for 2 cycles -> data=111 and valid/last/busy/done=0; release -> outputs unchanged with start=0.
REQ-027 start with rep_cnt=1, gap=0, out_ready=1 -> 8 consecutive valid terms 001,101,110,000,110,110,011,101; last only on the 8th; done the cycle after; busy high for 8 cycles.
REQ-028 rep_cnt=3, gap=2 -> 8 terms, 2 idle (111, valid=0), 8, 2, 8, then done; done exactly 28 cycles after term 0 first appears.
REQ-029 out_ready=0 for 3 cycles while term index 2 is presented -> 110 held for 4 cycles total; the full stream remains exactly the 8 terms in order.
REQ-030 Reset pulsed at term index 4 -> next cycle data=111, valid=0, no done; start mid-sequence (no reset) -> ignored and the stream is unchanged.
REQ-031 Loopback into sequence_detector with out_ready=1, rep_cnt=3, gap=0 -> sequence_found pulses exactly 3 times, each coincident with last.
